// File: rtl/enable_addr_pkg.sv
// enable_addr_pkg: shared rail-pair codes, FSM states and the encoded-zero word
package enable_addr_pkg;
  localparam logic [1:0] PAIR_NULL = 2'b00;
  localparam logic [1:0] PAIR_F = 2'b01;
  localparam logic [1:0] PAIR_T = 2'b10;
  localparam logic [1:0] PAIR_ILL = 2'b11;
  localparam int MAX_ADDR_W = 64;
  // Widest encoded zero; users slice off the low 2*ADDR_W bits
  localparam logic [2*MAX_ADDR_W-1:0] ENC_ZERO = {MAX_ADDR_W{PAIR_F}};
  typedef enum logic {IN_WAIT_DATA, IN_WAIT_NULL} in_state_t;
  typedef enum logic {OUT_NULL, OUT_DATA} out_state_t;
endpackage

// File: rtl/dr_complete_det.sv
// dr_complete_det: combinational complete/null/illegal detection over a dual-rail bus
module dr_complete_det
  import enable_addr_pkg::*;
#(
  parameter int W = 1
) (
  input  logic [2*W-1:0] bus,
  output logic           complete,
  output logic           is_null,
  output logic           illegal
);
  always_comb begin
    complete = 1'b1;
    illegal = 1'b0;
    for (int i = 0; i < W; i++) begin
      complete &= bus[2*i+:2] == PAIR_F || bus[2*i+:2] == PAIR_T;
      illegal |= bus[2*i+:2] == PAIR_ILL;
    end
  end
  assign is_null = ~|bus;
endmodule

// File: rtl/enable_addr_dr_fifo.sv
// enable_addr_dr_fifo: dual-rail address enable stage buffering DEPTH wavefronts
module enable_addr_dr_fifo
  import enable_addr_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DEPTH = 2,
  parameter bit PH_F_MODE = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 ph_in,
  input  logic [2*ADDR_W-1:0]        addr_in,
  output logic                       ack,
  output logic [2*ADDR_W-1:0]        addr_out,
  input  logic                       ack_in,
  output logic                       err,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [2*ADDR_W-1:0] ZERO_WORD = ENC_ZERO[2*ADDR_W-1:0];
  logic complete, is_null, illegal, cap, push, pop, load;
  in_state_t in_state, in_next;
  out_state_t out_state, out_next;
  logic [2*ADDR_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  dr_complete_det #(.W(ADDR_W + 1)) u_det (
    .bus({ph_in, addr_in}),
    .complete(complete),
    .is_null(is_null),
    .illegal(illegal)
  );
  // Full/empty use the pre-edge count: no bypass from pop to push
  assign cap = in_state == IN_WAIT_DATA && complete && !illegal && count < CW'(DEPTH);
  assign push = cap && (ph_in == PAIR_T || PH_F_MODE);
  assign load = out_state == OUT_NULL && count != '0 && !ack_in;
  assign pop = out_state == OUT_DATA && ack_in;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      in_state <= IN_WAIT_DATA;
      out_state <= OUT_NULL;
    end else begin
      in_state <= in_next;
      out_state <= out_next;
    end
  always_comb begin
    in_next = in_state == IN_WAIT_DATA ? (cap ? IN_WAIT_NULL : IN_WAIT_DATA)
                                       : (is_null ? IN_WAIT_DATA : IN_WAIT_NULL);
    out_next = out_state == OUT_NULL ? (load ? OUT_DATA : OUT_NULL)
                                     : (ack_in ? OUT_NULL : OUT_DATA);
  end
  always_comb ack = in_state == IN_WAIT_NULL;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr_out <= '0;
      err <= 1'b0;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      addr_out <= load ? mem[rd_ptr] : pop ? '0 : addr_out;
      err <= err | illegal;
      count <= count + CW'(push) - CW'(pop);
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= ph_in == PAIR_T ? addr_in : ZERO_WORD;
endmodule

// File: tb/tb_enable_addr_dr_fifo.sv
// tb_enable_addr_dr_fifo: directed scenarios plus a randomized scoreboard run
module tb_enable_addr_dr_fifo;
  logic clk = 1'b0, rst = 1'b1, ack_in = 1'b0;
  logic [1:0] ph_in = '0;
  logic [7:0] addr_in = '0;
  logic ack, err, ack2, err2;
  logic [7:0] addr_out, addr_out2;
  logic [1:0] count, count2;
  int checks = 0, errors = 0;

  enable_addr_dr_fifo #(.ADDR_W(4), .DEPTH(2), .PH_F_MODE(1'b1)) dut (
    .clk(clk), .rst(rst), .ph_in(ph_in), .addr_in(addr_in), .ack(ack),
    .addr_out(addr_out), .ack_in(ack_in), .err(err), .count(count)
  );
  enable_addr_dr_fifo #(.ADDR_W(4), .DEPTH(2), .PH_F_MODE(1'b0)) dut_nf (
    .clk(clk), .rst(rst), .ph_in(ph_in), .addr_in(addr_in), .ack(ack2),
    .addr_out(addr_out2), .ack_in(ack_in), .err(err2), .count(count2)
  );

  always #5 clk = ~clk;

  // Dual-rail encoding of a 4-bit value: 1 -> 10, 0 -> 01
  function automatic logic [7:0] enc(input logic [3:0] v);
    logic [7:0] r;
    for (int i = 0; i < 4; i++) r[2*i+:2] = v[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ph_in = '0; addr_in = '0; ack_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    ph_in = '0; addr_in = '0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (addr_out != '0 && !ack_in) ack_in = 1'b1;
      else if (addr_out == '0 && ack_in) ack_in = 1'b0;
      if (count == '0 && addr_out == '0 && !ack_in && !ack) break;
    end
    checks++;
    if (count !== 2'd0 || addr_out !== 8'h00) begin
      errors++;
      $display("FAIL %s_drain: count=%0d addr_out=%h expected 0/00", name, count, addr_out);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({ack, addr_out, err, count} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: ack=%b addr_out=%h err=%b count=%0d expected all 0", ack, addr_out, err, count);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    ph_in = 2'b10; addr_in = 8'h99; ack_in = 1'b0;
    tick();
    checks++;
    if (ack !== 1'b1 || count !== 2'd1 || addr_out !== 8'h00) begin
      errors++;
      $display("FAIL basic_capture: ack=%b count=%0d addr_out=%h expected 1/1/00", ack, count, addr_out);
    end
    tick();
    checks++;
    if (addr_out !== 8'h99) begin
      errors++;
      $display("FAIL basic_out: addr_out=%h expected 99", addr_out);
    end
    ph_in = '0; addr_in = '0;
    tick();
    checks++;
    if (ack !== 1'b0 || addr_out !== 8'h99) begin
      errors++;
      $display("FAIL basic_null: ack=%b addr_out=%h expected 0/99", ack, addr_out);
    end
    ack_in = 1'b1;
    tick();
    checks++;
    if (addr_out !== 8'h00 || count !== 2'd0) begin
      errors++;
      $display("FAIL basic_pop: addr_out=%h count=%0d expected 00/0", addr_out, count);
    end
    ack_in = 1'b0;
    tick();
  endtask

  task automatic test_phase_false();
    do_reset();
    ph_in = 2'b01; addr_in = 8'h99;
    tick();
    checks++;
    if (ack !== 1'b1 || ack2 !== 1'b1 || count !== 2'd1 || count2 !== 2'd0) begin
      errors++;
      $display("FAIL phf_capture: ack=%b ack_nf=%b count=%0d count_nf=%0d expected 1/1/1/0", ack, ack2, count, count2);
    end
    tick();
    checks++;
    if (addr_out !== 8'h55 || addr_out2 !== 8'h00) begin
      errors++;
      $display("FAIL phf_out: addr_out=%h addr_out_nf=%h expected 55/00", addr_out, addr_out2);
    end
    ph_in = '0; addr_in = '0;
    tick();
    checks++;
    if (ack !== 1'b0 || ack2 !== 1'b0) begin
      errors++;
      $display("FAIL phf_null: ack=%b ack_nf=%b expected 0/0", ack, ack2);
    end
    ack_in = 1'b1;
    tick();
    checks++;
    if (addr_out !== 8'h00 || count !== 2'd0 || addr_out2 !== 8'h00 || count2 !== 2'd0) begin
      errors++;
      $display("FAIL phf_pop: addr_out=%h count=%0d addr_out_nf=%h count_nf=%0d expected 00/0/00/0", addr_out, count, addr_out2, count2);
    end
    ack_in = 1'b0;
    tick();
  endtask

  task automatic test_fill_stall();
    ack_in = 1'b1;
    ph_in = 2'b10; addr_in = 8'h99;
    tick();
    ph_in = '0; addr_in = '0;
    tick();
    ph_in = 2'b10; addr_in = 8'h66;
    tick();
    checks++;
    if (ack !== 1'b1 || count !== 2'd2) begin
      errors++;
      $display("FAIL fill_two: ack=%b count=%0d expected 1/2", ack, count);
    end
    ph_in = '0; addr_in = '0;
    tick();
    ph_in = 2'b10; addr_in = 8'hA5;
    tick();
    tick();
    tick();
    checks++;
    if (ack !== 1'b0 || count !== 2'd2 || addr_out !== 8'h00) begin
      errors++;
      $display("FAIL fill_stall: ack=%b count=%0d addr_out=%h expected 0/2/00", ack, count, addr_out);
    end
    ack_in = 1'b0;
    tick();
    checks++;
    if (addr_out !== 8'h99) begin
      errors++;
      $display("FAIL fill_out0: addr_out=%h expected 99", addr_out);
    end
    ack_in = 1'b1;
    tick();
    checks++;
    if (count !== 2'd1 || ack !== 1'b0 || addr_out !== 8'h00) begin
      errors++;
      $display("FAIL fill_no_bypass: count=%0d ack=%b addr_out=%h expected 1/0/00", count, ack, addr_out);
    end
    ack_in = 1'b0;
    tick();
    checks++;
    if (addr_out !== 8'h66 || ack !== 1'b1 || count !== 2'd2) begin
      errors++;
      $display("FAIL fill_out1: addr_out=%h ack=%b count=%0d expected 66/1/2", addr_out, ack, count);
    end
    ph_in = '0; addr_in = '0; ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    tick();
    checks++;
    if (addr_out !== 8'hA5) begin
      errors++;
      $display("FAIL fill_out2: addr_out=%h expected a5", addr_out);
    end
    drain("fill");
  endtask

  task automatic test_partial();
    ph_in = 2'b10; addr_in = 8'h09;
    repeat (5) tick();
    checks++;
    if (ack !== 1'b0 || count !== 2'd0) begin
      errors++;
      $display("FAIL partial_hold: ack=%b count=%0d expected 0/0", ack, count);
    end
    addr_in = 8'h99;
    tick();
    checks++;
    if (ack !== 1'b1 || count !== 2'd1) begin
      errors++;
      $display("FAIL partial_complete: ack=%b count=%0d expected 1/1", ack, count);
    end
    drain("partial");
  endtask

  task automatic test_illegal();
    ph_in = 2'b10; addr_in = 8'hD9;
    tick();
    checks++;
    if (err !== 1'b1 || ack !== 1'b0 || count !== 2'd0) begin
      errors++;
      $display("FAIL illegal_detect: err=%b ack=%b count=%0d expected 1/0/0", err, ack, count);
    end
    addr_in = 8'h99;
    tick();
    checks++;
    if (ack !== 1'b1 || count !== 2'd1 || err !== 1'b1) begin
      errors++;
      $display("FAIL illegal_recover: ack=%b count=%0d err=%b expected 1/1/1", ack, count, err);
    end
    drain("illegal");
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL illegal_sticky: err=%b expected 1", err);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [3:0] v;
    int sent = 0, cyc = 0;
    bit busy = 0, t;
    ph_in = '0; addr_in = '0; ack_in = 1'b0;
    while ((sent < 40 || exp_q.size() != 0 || busy || ack || ack_in || addr_out != '0) && cyc < 3000) begin
      tick();
      cyc++;
      if (count > 2'd2) begin
        errors++;
        $display("FAIL rand_count: count=%0d exceeds 2", count);
      end
      if (busy && ack) begin
        ph_in = '0; addr_in = '0; busy = 0;
      end else if (!busy && !ack && sent < 40 && $urandom_range(0, 2) != 0) begin
        v = 4'($urandom_range(0, 15));
        t = 1'($urandom_range(0, 1));
        ph_in = t ? 2'b10 : 2'b01;
        addr_in = enc(v);
        exp_q.push_back(t ? enc(v) : enc(4'h0));
        sent++;
        busy = 1;
      end
      if (!ack_in && addr_out != '0 && $urandom_range(0, 1) == 1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_data: addr_out=%h expected nothing pending", addr_out);
        end else begin
          if (addr_out !== exp_q[0]) begin
            errors++;
            $display("FAIL rand_data: addr_out=%h expected %h", addr_out, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        ack_in = 1'b1;
      end else if (ack_in && addr_out == '0 && $urandom_range(0, 1) == 1) ack_in = 1'b0;
    end
    checks++;
    if (cyc >= 3000 || count !== 2'd0) begin
      errors++;
      $display("FAIL rand_finish: cycles=%0d count=%0d pending=%0d expected completion with count 0", cyc, count, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    ack_in = 1'b0;
    ph_in = 2'b10; addr_in = 8'h99;
    tick();
    ph_in = '0; addr_in = '0;
    tick();
    ph_in = 2'b10; addr_in = 8'h66;
    tick();
    checks++;
    if (count !== 2'd2 || addr_out !== 8'h99) begin
      errors++;
      $display("FAIL rmid_setup: count=%0d addr_out=%h expected 2/99", count, addr_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (addr_out !== 8'h00 || ack !== 1'b0 || count !== 2'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL rmid_async: addr_out=%h ack=%b count=%0d err=%b expected 00/0/0/0", addr_out, ack, count, err);
    end
    ph_in = '0; addr_in = '0;
    tick();
    rst = 1'b0;
    ph_in = 2'b10; addr_in = enc(4'h5);
    tick();
    tick();
    checks++;
    if (addr_out !== enc(4'h5) || ack !== 1'b1) begin
      errors++;
      $display("FAIL rmid_fresh: addr_out=%h ack=%b expected %h/1", addr_out, ack, enc(4'h5));
    end
    drain("rmid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_phase_false();
    test_fill_stall();
    test_partial();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/enable_addr_dr_fifo.md
Name: enable_addr_dr_fifo

Overview:
Clocked, parametrised successor of the dual-rail address enable stage. It accepts an ADDR_W-bit dual-rail address wavefront gated by a dual-rail phase signal and buffers up to DEPTH completed wavefronts. It presents them downstream with the four-phase DATA/NULL return-to-zero handshake. It sits between the PC address source and the memory-address consumer, and adds the following over the previous stage:
- width and depth parameters;
- a phase-false mode;
- illegal-code detection;
- occupancy reporting.

Parameters:
- ADDR_W, 4: address bits; each dual-rail bus is 2*ADDR_W wide. Bit i is carried as true rail [2i+1] and false rail [2i].
- DEPTH, 2: buffer entries; power of two, 2 or more.
- PH_F_MODE, 1: when phase is false, 1 forwards a DATA all-zero address; 0 consumes the wavefront without forwarding it.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: asynchronous reset, active-high.
- ph_in, in, 2: dual-rail phase; [1] is the true rail, [0] is the false rail.
- addr_in, in, 2*ADDR_W: dual-rail address from upstream.
- ack, out, 1: acknowledge to upstream. 1 means DATA captured and NULL is requested; 0 means ready for DATA.
- addr_out, out, 2*ADDR_W: dual-rail address to downstream. All zeros is NULL.
- ack_in, in, 1: acknowledge from downstream, same meaning as ack.
- err, out, 1: sticky error; set when any rail pair (phase or address) is 11.
- count, out, $clog2(DEPTH+1): number of buffered entries.

Behaviour:
- Reset (asynchronous, any time, including mid-handshake):
  - ack=0, addr_out=0 (NULL), err=0, count=0.
  - Both FSMs return to their initial states.
  - Buffer contents are don't-care.
- Completion is evaluated combinationally on the unregistered inputs:
  - complete: every pair (phase and address) is 01 or 10;
  - null: every rail is 0;
  - illegal: any pair is 11.
  Any other mix counts as partial.
- Input FSM, states IN_WAIT_DATA and IN_WAIT_NULL:
  - IN_WAIT_DATA:
    - complete, not illegal, and count<DEPTH at the edge: capture the entry, ack<=1, go to IN_WAIT_NULL.
    - If the buffer is full, hold; ack stays 0.
    - A partial wavefront is held, with no action.
  - Entry captured on phase 10: addr_in.
  - Entry captured on phase 01:
    - PH_F_MODE=1: the encoded zero, pattern 01 on every pair.
    - PH_F_MODE=0: nothing is pushed, but ack still rises (wavefront consumed).
  - IN_WAIT_NULL: on null, ack<=0 and go to IN_WAIT_DATA. Partial: hold.
  - Illegal at any edge:
    - err<=1; it stays set until rst;
    - in IN_WAIT_DATA the wavefront is not captured and the FSM stays;
    - in IN_WAIT_NULL the FSM waits for null as normal.
- Output FSM, states OUT_NULL and OUT_DATA:
  - OUT_NULL: if count>0 and ack_in==0, addr_out<=head entry and go to OUT_DATA.
  - OUT_DATA: when ack_in==1, pop the head, addr_out<=0 and go to OUT_NULL.
  - The next DATA is driven only after ack_in has returned to 0.
- Buffer:
  - Circular, with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
  - Push and pop on the same edge are allowed; count is unchanged.
  - Full and empty are judged on the pre-edge count. There is no bypass, so a push into a full buffer waits even when a pop happens on the same edge.
- Latency:
  - Complete input sampled at edge k gives ack=1 after edge k.
  - With the buffer empty and ack_in=0, addr_out is DATA after edge k+1.
- Outputs are registered and glitch-free; addr_out is never a partial wavefront.

Decomposition:
- Shared package enable_addr_pkg:
  - input and output state enums;
  - the localparam for the encoded-zero pattern;
  - the rail-pair code constants NULL=00, F=01, T=10, ILL=11.
- One sub-module, dr_complete_det, parameter W. It is combinational and, from a 2*W bus, gives complete, null and illegal. It is instanced once, over {ph_in, addr_in}.
- Buffer and FSMs live in the top level.

Test Plan:
All scenarios use ADDR_W=4, DEPTH=2 and PH_F_MODE=1 unless a scenario says otherwise.
1. Basic pass:
   - Stimulus: ph_in=10, addr_in=8'h99 (0xA); ack_in=0.
   - Response: ack=1 one edge later; addr_out=8'h99 one edge after that.
   - Stimulus: addr_in and ph_in go to 0, then ack_in=1.
   - Response: ack=0; addr_out=0; count back to 0.
2. Phase false:
   - Stimulus: ph_in=01, addr_in=8'h99.
   - Response: addr_out=8'h55.
   - Repeat with PH_F_MODE=0: ack cycles normally; addr_out stays 0; count stays 0.
3. Fill and stall:
   - Stimulus: ack_in held at 1; three wavefronts 8'h99, 8'h66, 8'hA5.
   - Response: the first two are acked and count=2; the third holds ack=0.
   - Stimulus: release ack_in.
   - Response: 8'h99, then 8'h66, then 8'hA5 are delivered in order, each separated by NULL; read and write pointers wrap.
4. Partial wavefront:
   - Stimulus: addr_in=8'h09 with the upper pairs 00, held 5 cycles.
   - Response: ack stays 0; count=0.
   - Stimulus: complete the wavefront to 8'h99.
   - Response: captured.
5. Illegal code:
   - Stimulus: addr_in=8'hD9 (pair 3 = 11).
   - Response: err=1; no capture.
   - Stimulus: a later legal wavefront.
   - Response: passes; err stays 1 until rst.
6. Reset mid-operation:
   - Stimulus: assert rst asynchronously while in OUT_DATA with count=2.
   - Response: addr_out=0, ack=0, count=0 immediately, without waiting for a clock edge.
   - After reset releases, a fresh wavefront passes normally.
